// File: rtl/helix_pkg.sv
// Shared widths, depth and delta-mode encoding for the helix thought/feedback path.
package helix_pkg;

  localparam int THOUGHT_W  = 16;
  localparam int ACTION_W   = 8;
  localparam int FEEDBACK_W = 8;
  localparam int LOOM_DEPTH = 4;

  typedef enum logic [1:0] {
    LOOM_XOR = 2'd0,
    LOOM_SUB = 2'd1,
    LOOM_ABS = 2'd2
  } loom_mode_e;

endpackage

// File: rtl/helix_loom_array_if.sv
// Efference, world and feedback stream handshakes of the loom comparator.
interface helix_loom_array_if #(
  parameter int THOUGHT_W  = helix_pkg::THOUGHT_W,
  parameter int ACTION_W   = helix_pkg::ACTION_W,
  parameter int FEEDBACK_W = helix_pkg::FEEDBACK_W
);

  logic                  efference_valid;
  logic                  efference_ready;
  logic [THOUGHT_W-1:0]  efference_data;
  logic                  world_valid;
  logic                  world_ready;
  logic [ACTION_W-1:0]   world_data;
  logic                  feedback_valid;
  logic                  feedback_ready;
  logic [FEEDBACK_W-1:0] feedback_delta;

  modport master (
    output efference_valid, efference_data, world_valid, world_data, feedback_ready,
    input  efference_ready, world_ready, feedback_valid, feedback_delta
  );

  modport slave (
    input  efference_valid, efference_data, world_valid, world_data, feedback_ready,
    output efference_ready, world_ready, feedback_valid, feedback_delta
  );

endinterface

// File: rtl/helix_loom_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on pop_data while not empty.
module helix_loom_fifo
  import helix_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == LVL_W'(0));
  assign level     = level_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers (wrap modulo DEPTH) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/helix_loom_array.sv
// Efference/world comparator: buffers predictions, pairs each world beat with the oldest one,
// registers a mode-dependent delta and keeps a saturating error-magnitude accumulator.
module helix_loom_array
  import helix_pkg::*;
#(
  parameter  int THOUGHT_W  = helix_pkg::THOUGHT_W,
  parameter  int ACTION_W   = helix_pkg::ACTION_W,
  parameter  int FEEDBACK_W = helix_pkg::FEEDBACK_W,
  parameter  int DEPTH      = helix_pkg::LOOM_DEPTH,
  parameter  int ACC_W      = FEEDBACK_W + 4,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  helix_loom_array_if.slave lnk,
  input  loom_mode_e        cfg_mode,
  input  logic              accum_clear,
  output logic [ACC_W-1:0]  error_accum,
  output logic              accum_sat,
  output logic [LVL_W-1:0]  fifo_level
);

  logic [FEEDBACK_W-1:0] head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  world_ready_s;
  logic                  pair_s;
  logic [FEEDBACK_W-1:0] a_s;
  logic [FEEDBACK_W-1:0] b_s;
  logic [FEEDBACK_W:0]   diff_s;
  logic [FEEDBACK_W:0]   neg_s;
  logic [FEEDBACK_W-1:0] abs_s;
  logic [FEEDBACK_W-1:0] delta_s;
  logic [FEEDBACK_W-1:0] mag_s;
  logic [ACC_W-1:0]      base_s;
  logic [ACC_W:0]        sum_s;
  logic [ACC_W-1:0]      accum_next_s;
  logic                  sat_next_s;
  logic                  fb_valid_r;
  logic [FEEDBACK_W-1:0] fb_delta_r;
  logic [ACC_W-1:0]      accum_r;
  logic                  sat_r;

  // Only the low FEEDBACK_W bits of a prediction take part in the comparison.
  helix_loom_fifo #(
    .WIDTH (FEEDBACK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lnk.efference_valid),
    .push_data (lnk.efference_data[FEEDBACK_W-1:0]),
    .pop       (pair_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  assign world_ready_s       = ~fifo_empty_s & (~fb_valid_r | lnk.feedback_ready);
  assign pair_s              = lnk.world_valid & world_ready_s;
  assign lnk.efference_ready = ~fifo_full_s;
  assign lnk.world_ready     = world_ready_s;
  assign lnk.feedback_valid  = fb_valid_r;
  assign lnk.feedback_delta  = fb_delta_r;
  assign error_accum         = accum_r;
  assign accum_sat           = sat_r;

  // Delta and magnitude for the head prediction against the current world beat.
  always_comb begin
    a_s    = head_s;
    b_s    = FEEDBACK_W'(lnk.world_data);
    diff_s = {1'b0, a_s} - {1'b0, b_s};
    neg_s  = ~diff_s + {{FEEDBACK_W{1'b0}}, 1'b1};
    if (diff_s[FEEDBACK_W]) begin
      abs_s = neg_s[FEEDBACK_W-1:0];
    end else begin
      abs_s = diff_s[FEEDBACK_W-1:0];
    end
    delta_s = a_s ^ b_s;
    mag_s   = a_s ^ b_s;
    case (cfg_mode)
      LOOM_SUB: begin
        // Sign and top bit disagree exactly when d leaves the signed FEEDBACK_W range.
        if (diff_s[FEEDBACK_W] & ~diff_s[FEEDBACK_W-1]) begin
          delta_s = {1'b1, {(FEEDBACK_W-1){1'b0}}};
        end else if (~diff_s[FEEDBACK_W] & diff_s[FEEDBACK_W-1]) begin
          delta_s = {1'b0, {(FEEDBACK_W-1){1'b1}}};
        end else begin
          delta_s = diff_s[FEEDBACK_W-1:0];
        end
        mag_s = abs_s;
      end
      LOOM_ABS: begin
        delta_s = abs_s;
        mag_s   = abs_s;
      end
      default: begin
        delta_s = a_s ^ b_s;
        mag_s   = a_s ^ b_s;
      end
    endcase
  end

  // Next accumulator state: clear applies first, then the pairing's magnitude is added.
  always_comb begin
    if (accum_clear) begin
      base_s = {ACC_W{1'b0}};
    end else begin
      base_s = accum_r;
    end
    sum_s = {1'b0, base_s} + {{(ACC_W + 1 - FEEDBACK_W){1'b0}}, mag_s};
    if (pair_s) begin
      if (sum_s[ACC_W]) begin
        accum_next_s = {ACC_W{1'b1}};
      end else begin
        accum_next_s = sum_s[ACC_W-1:0];
      end
    end else begin
      accum_next_s = base_s;
    end
    sat_next_s = (sat_r & ~accum_clear) | (&accum_next_s);
  end

  // Output register and accumulator; a held delta is only replaced by a new pairing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_valid_r <= 1'b0;
      fb_delta_r <= {FEEDBACK_W{1'b0}};
      accum_r    <= {ACC_W{1'b0}};
      sat_r      <= 1'b0;
    end else begin
      if (pair_s) begin
        fb_valid_r <= 1'b1;
        fb_delta_r <= delta_s;
      end else if (lnk.feedback_ready) begin
        fb_valid_r <= 1'b0;
      end
      accum_r <= accum_next_s;
      sat_r   <= sat_next_s;
    end
  end

endmodule

// File: tb/tb_helix_loom_array.sv
// Directed bench for helix_loom_array; expected deltas go into a scoreboard checked by a monitor.
module tb_helix_loom_array;
  import helix_pkg::*;

  typedef struct {
    logic [7:0]  delta;
    logic [11:0] acc;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  loom_mode_e  cfg_mode = LOOM_XOR;
  logic        accum_clear = 1'b0;
  logic [11:0] error_accum;
  logic        accum_sat;
  logic [2:0]  fifo_level;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  helix_loom_array_if #(.THOUGHT_W(16), .ACTION_W(8), .FEEDBACK_W(8)) lnk ();

  helix_loom_array #(
    .THOUGHT_W(16), .ACTION_W(8), .FEEDBACK_W(8), .DEPTH(4), .ACC_W(12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lnk         (lnk.slave),
    .cfg_mode    (cfg_mode),
    .accum_clear (accum_clear),
    .error_accum (error_accum),
    .accum_sat   (accum_sat),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_eff(input logic [15:0] d);
    int n = 0;
    lnk.efference_valid = 1'b1;
    lnk.efference_data  = d;
    while (!lnk.efference_ready && n < 50) begin
      tick();
      n++;
    end
    if (!lnk.efference_ready) begin
      n_checks++;
      $display("FAIL push_timeout: efference_ready stayed 0 for data 0x%0h, expected 1", d);
    end else begin
      tick();
    end
    lnk.efference_valid = 1'b0;
  endtask

  task automatic pair(input logic [7:0] w, input loom_mode_e m, input logic [7:0] ed,
                      input logic [11:0] ea, input logic es, input bit scored);
    int n = 0;
    exp_t e;
    lnk.world_valid = 1'b1;
    lnk.world_data  = w;
    cfg_mode        = m;
    while (!lnk.world_ready && n < 50) begin
      tick();
      n++;
    end
    if (!lnk.world_ready) begin
      n_checks++;
      $display("FAIL pair_timeout: world_ready stayed 0 for world 0x%0h, expected 1", w);
    end else begin
      if (scored) begin
        e.delta = ed; e.acc = ea; e.sat = es;
        sb_q.push_back(e);
      end
      tick();
    end
    lnk.world_valid = 1'b0;
  endtask

  task automatic clear_alone();
    accum_clear = 1'b1;
    tick();
    accum_clear = 1'b0;
  endtask

  // Scoreboard monitor: every accepted delta is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && lnk.feedback_valid && lnk.feedback_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_delta: got 0x%0h with no expectation queued", lnk.feedback_delta);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_delta", {24'd0, lnk.feedback_delta}, {24'd0, e.delta});
        chk("sb_accum", {20'd0, error_accum}, {20'd0, e.acc});
        chk("sb_sat", {31'd0, accum_sat}, {31'd0, e.sat});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    lnk.efference_valid = 1'b0;
    lnk.efference_data  = 16'h0000;
    lnk.world_valid     = 1'b0;
    lnk.world_data      = 8'h00;
    lnk.feedback_ready  = 1'b1;
    tick();
    tick();
    chk("por_valid", {31'd0, lnk.feedback_valid}, 32'd0);
    chk("por_level", {29'd0, fifo_level}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: reset mid-stream with 3 buffered and one delta held.
    push_eff(16'h0011); push_eff(16'h0022); push_eff(16'h0033); push_eff(16'h0044);
    lnk.feedback_ready = 1'b0;
    pair(8'h00, LOOM_XOR, 8'h00, 12'h000, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'd0, lnk.feedback_valid}, 32'd1);
    chk("pre_rst_delta", {24'd0, lnk.feedback_delta}, 32'h11);
    chk("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, lnk.feedback_valid}, 32'd0);
    chk("rst_delta", {24'd0, lnk.feedback_delta}, 32'd0);
    chk("rst_accum", {20'd0, error_accum}, 32'd0);
    chk("rst_sat", {31'd0, accum_sat}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_eff_ready", {31'd0, lnk.efference_ready}, 32'd1);
    chk("rst_world_ready", {31'd0, lnk.world_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    lnk.feedback_ready = 1'b1;
    tick();

    // 2: XOR pairing, no bypass, one-cycle latency.
    lnk.efference_valid = 1'b1;
    lnk.efference_data  = 16'h00A5;
    #1;
    chk("no_bypass", {31'd0, lnk.world_ready}, 32'd0);
    push_eff(16'h00A5);
    chk("eff_visible", {31'd0, lnk.world_ready}, 32'd1);
    pair(8'h0F, LOOM_XOR, 8'hAA, 12'h0AA, 1'b0, 1'b1);
    chk("latency_valid", {31'd0, lnk.feedback_valid}, 32'd1);

    // 3: SUB saturation, ABS, reserved mode.
    clear_alone();
    push_eff(16'h0010); pair(8'hF0, LOOM_SUB, 8'h80, 12'h0E0, 1'b0, 1'b1);
    push_eff(16'h00F0); pair(8'h10, LOOM_SUB, 8'h7F, 12'h1C0, 1'b0, 1'b1);
    push_eff(16'h0010); pair(8'hF0, LOOM_ABS, 8'hE0, 12'h2A0, 1'b0, 1'b1);
    push_eff(16'h00F0); pair(8'h10, LOOM_ABS, 8'hE0, 12'h380, 1'b0, 1'b1);
    push_eff(16'h00A5); pair(8'h0F, loom_mode_e'(2'd3), 8'hAA, 12'h42A, 1'b0, 1'b1);

    // 4: fill, held 5th beat, no push-when-full, strict order.
    clear_alone();
    push_eff(16'h1201); push_eff(16'h3402); push_eff(16'h5603); push_eff(16'h7804);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_eff_ready", {31'd0, lnk.efference_ready}, 32'd0);
    lnk.efference_valid = 1'b1;
    lnk.efference_data  = 16'h00FF;
    tick(); tick();
    chk("held_level", {29'd0, fifo_level}, 32'd4);
    pair(8'h00, LOOM_XOR, 8'h01, 12'h001, 1'b0, 1'b1);
    chk("no_push_full", {29'd0, fifo_level}, 32'd3);
    pair(8'h00, LOOM_XOR, 8'h02, 12'h003, 1'b0, 1'b1);
    lnk.efference_valid = 1'b0;
    chk("push_pop_level", {29'd0, fifo_level}, 32'd3);
    pair(8'h00, LOOM_XOR, 8'h03, 12'h006, 1'b0, 1'b1);
    pair(8'h00, LOOM_XOR, 8'h04, 12'h00A, 1'b0, 1'b1);
    pair(8'h00, LOOM_XOR, 8'hFF, 12'h109, 1'b0, 1'b1);
    chk("drained_level", {29'd0, fifo_level}, 32'd0);

    // 5: backpressure holds the delta and blocks pairing.
    clear_alone();
    push_eff(16'h0033); push_eff(16'h0044);
    lnk.feedback_ready = 1'b0;
    pair(8'h00, LOOM_XOR, 8'h33, 12'h033, 1'b0, 1'b1);
    lnk.world_valid = 1'b1;
    lnk.world_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("bp_delta", {24'd0, lnk.feedback_delta}, 32'h33);
      chk("bp_world_ready", {31'd0, lnk.world_ready}, 32'd0);
      chk("bp_level", {29'd0, fifo_level}, 32'd1);
      tick();
    end
    lnk.feedback_ready = 1'b1;
    #1;
    chk("release_world_ready", {31'd0, lnk.world_ready}, 32'd1);
    begin
      exp_t e;
      e.delta = 8'h44; e.acc = 12'h077; e.sat = 1'b0;
      sb_q.push_back(e);
    end
    tick();
    lnk.world_valid = 1'b0;
    chk("release_delta", {24'd0, lnk.feedback_delta}, 32'h44);
    tick();
    chk("accepted_idle", {31'd0, lnk.feedback_valid}, 32'd0);

    // 6: accumulator saturation and clear behaviour.
    clear_alone();
    for (int i = 1; i <= 17; i++) begin
      acc = (i * 255 > 4095) ? 4095 : i * 255;
      push_eff(16'h00FF);
      pair(8'h00, LOOM_XOR, 8'hFF, acc[11:0], (acc == 4095), 1'b1);
    end
    clear_alone();
    chk("clear_accum", {20'd0, error_accum}, 32'd0);
    chk("clear_sat", {31'd0, accum_sat}, 32'd0);
    push_eff(16'h00FF);
    pair(8'h00, LOOM_XOR, 8'hFF, 12'h0FF, 1'b0, 1'b1);
    push_eff(16'h0005);
    accum_clear = 1'b1;
    pair(8'h00, LOOM_XOR, 8'h05, 12'h005, 1'b0, 1'b1);
    accum_clear = 1'b0;

    tick(); tick(); tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
